// File: rtl/gactx_dir_collector.sv
// gactx_dir_collector
//   Collects per-channel traceback direction codes from NUM_CH GACT-X arrays,
//   packs DIRS_PER_WORD codes into one W-bit word and stores each finished
//   word in that channel's private DEPTH x W memory. A shared registered read
//   port returns any stored word from any channel.
//
// Ports
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   ch_start     : per-channel start pulse (IDLE/DONE -> COLLECT)
//   ch_clear     : per-channel done acknowledge (DONE -> IDLE)
//   dir_valid    : per-channel direction strobe
//   dir          : channel c code at [c*DIR_BITS +: DIR_BITS]
//   dir_last     : final direction of a traceback, qualified by dir_valid
//   rd_ch/rd_addr: readout select; rd_data is valid one cycle later
//   word_count   : words stored per channel, (ADDR_WIDTH+1) bits each
//   ch_busy      : channel in COLLECT
//   ch_done      : channel in DONE
//   ch_overflow  : channel dropped at least one word this run
//   dbg_state    : raw FSM state per channel, 2 bits each
//
// Handshake: dir_valid is a one-sided strobe with no ready. A channel in
// COLLECT accepts a direction every cycle that dir_valid is high; strobes
// seen in any other state are discarded. There is never backpressure.
module gactx_dir_collector #(
  parameter int NUM_CH        = 2,
  parameter int DIR_BITS      = 2,
  parameter int DIRS_PER_WORD = 32,
  parameter int ADDR_WIDTH    = 14
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CH-1:0]                         ch_start,
  input  logic [NUM_CH-1:0]                         ch_clear,
  input  logic [NUM_CH-1:0]                         dir_valid,
  input  logic [NUM_CH*DIR_BITS-1:0]                dir,
  input  logic [NUM_CH-1:0]                         dir_last,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  input  logic [ADDR_WIDTH-1:0]                     rd_addr,
  output logic [DIR_BITS*DIRS_PER_WORD-1:0]         rd_data,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]          word_count,
  output logic [NUM_CH-1:0]                         ch_busy,
  output logic [NUM_CH-1:0]                         ch_done,
  output logic [NUM_CH-1:0]                         ch_overflow,
  output logic [NUM_CH*2-1:0]                       dbg_state
);

  localparam int W     = DIR_BITS * DIRS_PER_WORD;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SLW   = (DIRS_PER_WORD > 1) ? $clog2(DIRS_PER_WORD) : 1;
  localparam int RDW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  logic [W-1:0] rd_words [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t              state_q, state_d;
    logic [SLW-1:0]      slot_q, slot_d;
    logic [W-1:0]        pack_q, pack_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [DIR_BITS-1:0] code;
    logic [W-1:0]        merged;
    logic                word_done;
    logic                full;
    logic                we;
    logic [W-1:0]        mem_q [DEPTH];
    logic [W-1:0]        rd_word_q;

    assign code   = dir[c*DIR_BITS +: DIR_BITS];
    // Pack register already holds zeros above the current slot, so OR-ing the
    // new code in yields the word with unfilled slots zero.
    assign merged = pack_q | (W'(code) << (slot_q * DIR_BITS));
    assign word_done = (state_q == S_COLLECT) && dir_valid[c] &&
                       ((slot_q == SLW'(DIRS_PER_WORD - 1)) || dir_last[c]);
    // word_count saturates at DEPTH, which is the only value with the MSB set.
    assign full = cnt_q[ADDR_WIDTH];
    assign we   = word_done && !full && !rst;

    always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      pack_d  = pack_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
        S_IDLE: begin
          if (ch_start[c]) begin
            state_d = S_COLLECT;
            slot_d  = '0;
            pack_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        S_COLLECT: begin
          if (dir_valid[c]) begin
            if (word_done) begin
              slot_d = '0;
              pack_d = '0;
              if (full) ovf_d = 1'b1;
              else      cnt_d = cnt_q + 1'b1;
            end else begin
              slot_d = slot_q + 1'b1;
              pack_d = merged;
            end
            if (dir_last[c]) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (ch_start[c]) begin
            state_d = S_COLLECT;
            slot_d  = '0;
            pack_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else if (ch_clear[c]) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        slot_q  <= '0;
        pack_q  <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        slot_q  <= slot_d;
        pack_q  <= pack_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
      end
    end

    // Memory is deliberately not reset; read-before-write on a shared address.
    always_ff @(posedge clk) begin
      if (we) mem_q[cnt_q[ADDR_WIDTH-1:0]] <= merged;
      rd_word_q <= mem_q[rd_addr];
    end

    assign rd_words[c]                            = rd_word_q;
    assign word_count[c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1] = cnt_q;
    assign ch_busy[c]                             = (state_q == S_COLLECT);
    assign ch_done[c]                             = (state_q == S_DONE);
    assign ch_overflow[c]                         = ovf_q;
    assign dbg_state[c*2 +: 2]                    = state_q;
  end

  // Selected channel and a range flag are registered alongside the per-channel
  // read words; the flag also forces rd_data to zero straight out of reset.
  logic [RDW-1:0] rd_ch_q;
  logic           rd_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ch_q <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      rd_ch_q <= rd_ch;
      rd_ok_q <= (32'(rd_ch) < NUM_CH);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ok_q && (rd_ch_q == RDW'(i))) rd_data = rd_words[i];
    end
  end

endmodule

// File: tb/tb_gactx_dir_collector.sv
module tb_gactx_dir_collector;

  localparam int NCH = 3;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int DPW = 32;
  localparam int W   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NCH-1:0]    ch_start = '0, ch_clear = '0, dir_valid = '0, dir_last = '0;
  logic [NCH*2-1:0]  dir = '0;
  logic [1:0]        rd_ch = '0;
  logic [AW-1:0]     rd_addr = '0;
  logic [W-1:0]      rd_data;
  logic [NCH*(AW+1)-1:0] word_count;
  logic [NCH-1:0]    ch_busy, ch_done, ch_overflow;
  logic [NCH*2-1:0]  dbg_state;

  gactx_dir_collector #(
    .NUM_CH(NCH), .DIR_BITS(2), .DIRS_PER_WORD(DPW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_clear(ch_clear),
    .dir_valid(dir_valid), .dir(dir), .dir_last(dir_last),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .word_count(word_count), .ch_busy(ch_busy), .ch_done(ch_done),
    .ch_overflow(ch_overflow), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit           known_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: channel activity as plain flags, partial word built up
  // arithmetically from code * 4**slot, memory as a 2-D array.
  bit           m_busy [NCH];
  bit           m_done [NCH];
  bit           m_ovf  [NCH];
  int           m_cnt  [NCH];
  int           m_nslot[NCH];
  logic [W-1:0] m_part [NCH];
  logic [W-1:0] m_mem  [NCH][DEP];
  bit           m_wr   [NCH][DEP];

  task automatic model_step();
    logic [W-1:0] e;
    bit k;
    int code;
    if (rst) begin
      e = '0; k = 1'b1;
    end else if (rd_ch >= NCH) begin
      e = '0; k = 1'b1;
    end else begin
      e = m_mem[rd_ch][rd_addr]; k = m_wr[rd_ch][rd_addr];
    end
    exp_q.push_back(e);
    known_q.push_back(k);
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_busy[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
        m_cnt[c] = 0; m_nslot[c] = 0; m_part[c] = '0;
      end else if (!m_busy[c]) begin
        if (ch_start[c]) begin
          m_busy[c] = 1; m_done[c] = 0; m_ovf[c] = 0;
          m_cnt[c] = 0; m_nslot[c] = 0; m_part[c] = '0;
        end else if (m_done[c] && ch_clear[c]) begin
          m_done[c] = 0;
        end
      end else if (dir_valid[c]) begin
        code = int'(dir[c*2 +: 2]);
        m_part[c] = m_part[c] + (64'(code) << (2 * m_nslot[c]));
        m_nslot[c]++;
        if (m_nslot[c] == DPW || dir_last[c]) begin
          if (m_cnt[c] < DEP) begin
            m_mem[c][m_cnt[c]] = m_part[c];
            m_wr[c][m_cnt[c]]  = 1;
            m_cnt[c]++;
          end else begin
            m_ovf[c] = 1;
          end
          m_part[c] = '0;
          m_nslot[c] = 0;
        end
        if (dir_last[c]) begin
          m_busy[c] = 0; m_done[c] = 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [W-1:0] e;
    bit k;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    k = known_q.pop_front();
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("word_count[%0d]", c), 64'(word_count[c*(AW+1) +: AW+1]), 64'(m_cnt[c]));
      check_val($sformatf("ch_busy[%0d]", c), 64'(ch_busy[c]), 64'(m_busy[c]));
      check_val($sformatf("ch_done[%0d]", c), 64'(ch_done[c]), 64'(m_done[c]));
      check_val($sformatf("ch_overflow[%0d]", c), 64'(ch_overflow[c]), 64'(m_ovf[c]));
    end
    if (k) check_val("rd_data", rd_data, e);
    ch_start = '0; ch_clear = '0; dir_valid = '0; dir_last = '0;
  endtask

  task automatic drive_dir(input int c, input int code, input bit last);
    dir_valid[c] = 1'b1;
    dir[c*2 +: 2] = 2'(code);
    dir_last[c] = last;
  endtask

  task automatic read_check(input int c, input int a, input logic [W-1:0] exp, input string tag);
    rd_ch = 2'(c);
    rd_addr = AW'(a);
    tick();
    check_val(tag, rd_data, exp);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEP; a++) begin
        m_wr[c][a] = 0; m_mem[c][a] = '0;
      end

    // reset
    rst = 1'b1;
    tick(); tick();
    check_val("reset rd_data", rd_data, '0);
    check_val("reset busy", 64'(ch_busy), '0);
    rst = 1'b0;
    tick();

    // ch0: 32 x code 1, last on 32nd
    ch_start[0] = 1'b1; tick();
    for (int i = 0; i < 32; i++) begin
      drive_dir(0, 1, i == 31);
      tick();
    end
    check_val("ch0 done after last", 64'(ch_done[0]), 64'd1);
    check_val("ch0 count", 64'(word_count[0 +: AW+1]), 64'd1);
    read_check(0, 0, 64'h5555_5555_5555_5555, "ch0 word0");

    // ch1: codes 1,2,3, last on 3rd
    ch_start[1] = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      drive_dir(1, i + 1, i == 2);
      tick();
    end
    check_val("ch1 count", 64'(word_count[(AW+1) +: AW+1]), 64'd1);
    read_check(1, 0, 64'h39, "ch1 word0");
    read_check(0, 0, 64'h5555_5555_5555_5555, "ch0 untouched");
    read_check(3, 0, 64'h0, "rd_ch out of range");

    // ch0+ch1 concurrently, 64 valids, code = i mod 4
    ch_start[0] = 1'b1; ch_start[1] = 1'b1; tick();
    for (int i = 0; i < 64; i++) begin
      drive_dir(0, i % 4, i == 63);
      drive_dir(1, i % 4, i == 63);
      tick();
    end
    read_check(0, 1, 64'hE4E4_E4E4_E4E4_E4E4, "ch0 word1 E4");
    read_check(1, 0, 64'hE4E4_E4E4_E4E4_E4E4, "ch1 word0 E4");
    check_val("ch1 count 2", 64'(word_count[(AW+1) +: AW+1]), 64'd2);

    // ch0 overflow: 5*32+1 directions on a 4-word memory
    ch_start[0] = 1'b1; tick();
    for (int i = 0; i < 161; i++) begin
      drive_dir(0, $urandom_range(0, 3), i == 160);
      tick();
    end
    check_val("ovf count", 64'(word_count[0 +: AW+1]), 64'd4);
    check_val("ovf flag", 64'(ch_overflow[0]), 64'd1);
    check_val("ovf done", 64'(ch_done[0]), 64'd1);
    for (int a = 0; a < DEP; a++) read_check(0, a, m_mem[0][a], "ovf word");

    // reset mid-collect, then restart with one code-3 last
    ch_start[0] = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      drive_dir(0, 2, 1'b0);
      tick();
    end
    drive_dir(0, 1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    ch_start[0] = 1'b1; tick();
    drive_dir(0, 3, 1'b1); tick();
    read_check(0, 0, 64'h3, "restart word0");
    check_val("restart count", 64'(word_count[0 +: AW+1]), 64'd1);
    check_val("restart ovf", 64'(ch_overflow[0]), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        ch_start[c]  = ($urandom_range(0, 19) == 0);
        ch_clear[c]  = ($urandom_range(0, 9) == 0);
        dir_valid[c] = ($urandom_range(0, 2) != 0);
        dir_last[c]  = ($urandom_range(0, 39) == 0);
        dir[c*2 +: 2] = 2'($urandom_range(0, 3));
      end
      rd_ch   = 2'($urandom_range(0, 3));
      rd_addr = AW'($urandom_range(0, DEP - 1));
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
